// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule applied when a request is accepted.
package lsu_pkg;

    localparam int PALAVRAS_LOG2_PADRAO = 8;

    localparam logic [1:0] TAM_BYTE = 2'b00;
    localparam logic [1:0] TAM_HALF = 2'b01;
    localparam logic [1:0] TAM_WORD = 2'b10;
    localparam logic [1:0] TAM_INV  = 2'b11;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        LEITURA = 3'd1,
        ESCRITA = 3'd2,
        RETORNO = 3'd3,
        ERRO    = 3'd4
    } estado_t;

    // Illegal size, or an access that does not sit on its natural boundary.
    function automatic logic erro_alinhamento(input logic [1:0] tam, input logic [1:0] desl);
        logic e;
        case (tam)
            TAM_BYTE: e = 1'b0;
            TAM_HALF: e = desl[0];
            TAM_WORD: e = (desl != 2'b00);
            default:  e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/unidade_load_store_if.sv
// Request/response handshake between the execute stage (master) and the
// load/store unit (slave).
interface unidade_load_store_if;

    logic        req_valid;
    logic        req_escrita;
    logic [1:0]  req_tamanho;
    logic        req_sem_sinal;
    logic [31:0] req_endereco;
    logic [31:0] req_dado;
    logic        pronto;
    logic        resp_valid;
    logic [31:0] resp_dado;
    logic        resp_erro;

    modport master (
        output req_valid, req_escrita, req_tamanho, req_sem_sinal, req_endereco, req_dado,
        input  pronto, resp_valid, resp_dado, resp_erro
    );

    modport slave (
        input  req_valid, req_escrita, req_tamanho, req_sem_sinal, req_endereco, req_dado,
        output pronto, resp_valid, resp_dado, resp_erro
    );

endinterface

// File: rtl/alinhador_dados.sv
// Byte-lane steering: extracts and extends load data from a RAM word, and
// merges sub-word store data into the word read back from RAM.
module alinhador_dados
    import lsu_pkg::*;
(
    input  logic [31:0] dado_memoria,
    input  logic [31:0] dado_req,
    input  logic [1:0]  tamanho,
    input  logic        sem_sinal,
    input  logic [1:0]  deslocamento,
    output logic [31:0] dado_carga,
    output logic [31:0] dado_mesclado
);

    logic [7:0]  w_byte;
    logic [15:0] w_meia;

    // Lane extraction and sign/zero extension for loads (lane 0 = bits 7:0).
    always_comb begin
        w_byte = 8'd0;
        w_meia = 16'd0;
        case (deslocamento)
            2'd0:    w_byte = dado_memoria[7:0];
            2'd1:    w_byte = dado_memoria[15:8];
            2'd2:    w_byte = dado_memoria[23:16];
            2'd3:    w_byte = dado_memoria[31:24];
            default: w_byte = 8'd0;
        endcase
        if (deslocamento[1]) begin
            w_meia = dado_memoria[31:16];
        end else begin
            w_meia = dado_memoria[15:0];
        end
        case (tamanho)
            TAM_BYTE: dado_carga = sem_sinal ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            TAM_HALF: dado_carga = sem_sinal ? {16'd0, w_meia} : {{16{w_meia[15]}}, w_meia};
            TAM_WORD: dado_carga = dado_memoria;
            default:  dado_carga = 32'd0;
        endcase
    end

    // Store merge: only the addressed lane(s) change; a word store replaces everything.
    always_comb begin
        dado_mesclado = dado_memoria;
        case (tamanho)
            TAM_BYTE: dado_mesclado[{deslocamento, 3'b000} +: 8] = dado_req[7:0];
            TAM_HALF: dado_mesclado[{deslocamento[1], 4'b0000} +: 16] = dado_req[15:0];
            TAM_WORD: dado_mesclado = dado_req;
            default:  dado_mesclado = dado_memoria;
        endcase
    end

endmodule

// File: rtl/unidade_load_store.sv
// Load/store unit in front of a word-only data RAM: one request at a time,
// read-modify-write for sub-word stores, error reporting without RAM access.
module unidade_load_store
    import lsu_pkg::*;
#(
    parameter int PALAVRAS_LOG2 = PALAVRAS_LOG2_PADRAO
) (
    input  logic                 clock,
    input  logic                 reset,
    unidade_load_store_if.slave  bus,
    output logic [31:0]          mem_endereco,
    output logic [31:0]          mem_dado_escrita,
    output logic                 mem_MemRead,
    output logic                 mem_MemWrite,
    input  logic [31:0]          mem_dado_leitura
);

    estado_t                  r_estado;
    logic                     r_escrita;
    logic [1:0]               r_tamanho;
    logic                     r_sem_sinal;
    logic [PALAVRAS_LOG2+1:0] r_endereco;
    logic [31:0]              r_dado;

    logic                     w_erro;
    logic [31:0]              w_carga;
    logic [31:0]              w_mesclado;

    // Request validity, evaluated on the live request while idle.
    always_comb begin
        if (bus.req_endereco[31:PALAVRAS_LOG2+2] != {(30-PALAVRAS_LOG2){1'b0}}) begin
            w_erro = 1'b1;
        end else begin
            w_erro = erro_alinhamento(bus.req_tamanho, bus.req_endereco[1:0]);
        end
    end

    // Control FSM and latched request fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado    <= OCIOSO;
            r_escrita   <= 1'b0;
            r_tamanho   <= TAM_BYTE;
            r_sem_sinal <= 1'b0;
            r_endereco  <= {(PALAVRAS_LOG2+2){1'b0}};
            r_dado      <= 32'd0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (bus.req_valid) begin
                        r_escrita   <= bus.req_escrita;
                        r_tamanho   <= bus.req_tamanho;
                        r_sem_sinal <= bus.req_sem_sinal;
                        r_endereco  <= bus.req_endereco[PALAVRAS_LOG2+1:0];
                        r_dado      <= bus.req_dado;
                        if (w_erro) begin
                            r_estado <= ERRO;
                        end else if (bus.req_escrita && (bus.req_tamanho == TAM_WORD)) begin
                            r_estado <= ESCRITA;
                        end else begin
                            r_estado <= LEITURA;
                        end
                    end else begin
                        r_estado <= OCIOSO;
                    end
                end
                LEITURA: r_estado <= r_escrita ? ESCRITA : RETORNO;
                ESCRITA: r_estado <= OCIOSO;
                RETORNO: r_estado <= OCIOSO;
                ERRO:    r_estado <= OCIOSO;
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    alinhador_dados u_alinhador (
        .dado_memoria  (mem_dado_leitura),
        .dado_req      (r_dado),
        .tamanho       (r_tamanho),
        .sem_sinal     (r_sem_sinal),
        .deslocamento  (r_endereco[1:0]),
        .dado_carga    (w_carga),
        .dado_mesclado (w_mesclado)
    );

    assign mem_endereco = {{(32-PALAVRAS_LOG2){1'b0}}, r_endereco[PALAVRAS_LOG2+1:2]};

    // State decode; completion and write strobe are suppressed while reset is high
    // so an interrupted store never reaches the RAM.
    always_comb begin
        bus.pronto       = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_erro    = 1'b0;
        bus.resp_dado    = 32'd0;
        mem_MemRead      = 1'b0;
        mem_MemWrite     = 1'b0;
        mem_dado_escrita = 32'd0;
        case (r_estado)
            OCIOSO:  bus.pronto = 1'b1;
            LEITURA: mem_MemRead = 1'b1;
            ESCRITA: begin
                mem_MemWrite     = !reset;
                mem_dado_escrita = w_mesclado;
                bus.resp_valid   = !reset;
            end
            RETORNO: begin
                bus.resp_valid = !reset;
                bus.resp_dado  = w_carga;
            end
            ERRO: begin
                bus.resp_valid = !reset;
                bus.resp_erro  = !reset;
            end
            default: bus.pronto = 1'b0;
        endcase
    end

endmodule

// File: doc/unidade_load_store.md
Name: unidade_load_store

Overview:
- Sits between execute stage and word-only data RAM (mem_dados). Takes one load/store request at a time and drives the RAM's address, data, read and write strobes.
- Handles byte/half/word access: sub-word stores via read-modify-write; loads return sign- or zero-extended data.
- Flags misaligned, out-of-range and illegal-size requests without touching memory.
- Processor stalls on pronto=0.

Parameters:
- PALAVRAS_LOG2, 8, log2 of RAM depth in 32-bit words (256 words, byte range 0..1023).

Ports:
- clock  in  1  single system clock; also wired to RAM clock and clock_write.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present; accepted only when pronto=1.
- req_escrita  in  1  1=store, 0=load.
- req_tamanho  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_sem_sinal  in  1  loads only: 1=zero-extend, 0=sign-extend.
- req_endereco  in  32  byte address.
- req_dado  in  32  store data, right-aligned.
- pronto  out  1  ready to accept.
- resp_valid  out  1  one-cycle completion pulse (loads and stores).
- resp_dado  out  32  load result, valid with resp_valid; 0 for stores/errors.
- resp_erro  out  1  request rejected, valid with resp_valid.
- mem_endereco  out  32  word index = byte_addr[PALAVRAS_LOG2+1:2], zero-extended.
- mem_dado_escrita  out  32  word to write.
- mem_MemRead  out  1  RAM read enable (RAM samples on posedge).
- mem_MemWrite  out  1  RAM write enable (RAM writes on negedge).
- mem_dado_leitura  in  32  registered RAM read data.

Behaviour:
- Reset: state OCIOSO; pronto=1; resp_valid=0; resp_erro=0; resp_dado=0; mem_MemRead=0; mem_MemWrite=0; mem_endereco=0; mem_dado_escrita=0.
- Accept: when pronto & req_valid at posedge k, latch all req_* fields. pronto=1 only in OCIOSO.
- Error check at accept. Any of the following sets erro:
  - tamanho=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:PALAVRAS_LOG2+2]!=0.
- Error path: state ERRO in cycle k+1 with resp_valid=1, resp_erro=1, no strobes, then back to OCIOSO.
- States (transitions on posedge):
  - OCIOSO: accept. Load or sub-word store -> LEITURA. Word store -> ESCRITA. Error -> ERRO.
  - LEITURA: mem_MemRead=1, mem_endereco driven. Load -> RETORNO. Sub-word store -> ESCRITA.
  - ESCRITA: mem_MemWrite=1.
    - Word store: mem_dado_escrita=req_dado.
    - Byte store: mem_dado_leitura with byte lane addr[1:0] replaced by req_dado[7:0].
    - Half store: half lane addr[1] replaced by req_dado[15:0].
    - resp_valid=1 in this cycle -> OCIOSO.
  - RETORNO: select lane by addr[1:0] from mem_dado_leitura; extend per req_sem_sinal; resp_dado driven, resp_valid=1 -> OCIOSO.
- Byte lanes little-endian: lane 0 = bits[7:0].
- Latency from accept edge k:
  - LW/LB/LH: resp_valid in cycle k+2.
  - SW: k+1.
  - SB/SH: k+2.
  - error: k+1.
  - Next accept possible in the resp_valid cycle's following edge.
- Strobe rules: mem_MemRead and mem_MemWrite never both 1. Strobes are combinational from state, and mem_MemWrite is gated by !reset, so no RAM write occurs in a cycle with reset=1.
- Reset mid-operation: the in-flight request is dropped with no resp_valid; a pending sub-word store leaves RAM unchanged.
- req_valid while pronto=0 is ignored; the requester holds it.

Decomposition:
- Shared package lsu_pkg:
  - size encodings TAM_BYTE/TAM_HALF/TAM_WORD/TAM_INV;
  - state enum OCIOSO/LEITURA/ESCRITA/RETORNO/ERRO;
  - PALAVRAS_LOG2 default.
- One natural sub-module: alinhador_dados (combinational). Does lane extraction plus sign/zero extension for loads, and lane merge for stores; used in RETORNO and ESCRITA.

Test Plan:
- Reset, then SW addr 0x010 data 0xDEADBEEF; LW 0x010 -> SW resp_valid at k+1, mem_endereco=4; LW resp_dado=0xDEADBEEF at k+2.
- SB addr 0x011 data 0xA5 over word 0xDEADBEEF -> LEITURA then ESCRITA; stored word 0xDEADA5EF; LBU 0x011 -> 0x000000A5; LB 0x011 -> 0xFFFFFFA5.
- SH addr 0x012 data 0x8001 -> word 0x8001A5EF; LH 0x012 -> 0xFFFF8001; LHU -> 0x00008001.
- LW 0x013, SH 0x011, tamanho=11, LW 0x400 -> each resp_erro=1 at k+1; no mem_MemRead/mem_MemWrite pulse; RAM unchanged.
- SB issued, reset asserted in its ESCRITA cycle -> mem_MemWrite stays 0; then pronto=1, all outputs at reset values, and LW returns the pre-store value.
- Back-to-back: req_valid held high with 3 queued requests -> each accepted only when pronto=1; exactly one resp_valid per request, in order.
